// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite slave-side signal bundle for ahb_slave_mem.
// The master modport is the bus/testbench side and the slave modport is the memory side.
interface ahb_slave_mem_if #(
  parameter int unsigned AHB_DW = 32,
  parameter int unsigned AHB_AW = 32
);
  logic              hsel;
  logic [AHB_AW-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [AHB_DW-1:0] hwdata;
  logic              hreadyin;
  logic              hreadyout;
  logic              hresp;
  logic [AHB_DW-1:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hreadyin,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hreadyin,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave memory with programmable wait states and a two-cycle ERROR response.
// Define AHB_SLV_BURST_CHECK_EN to enable SEQ burst tracking and the sticky burst_err flag.
module ahb_slave_mem #(
  parameter int unsigned AHB_DW    = 32,
  parameter int unsigned AHB_AW    = 32,
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  ahb_slave_mem_if.slave        bus,
  input  logic [3:0]            wait_cfg,
  output logic                  burst_err
);

  localparam int unsigned NumBytes = AHB_DW / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);
  localparam int unsigned IdxW     = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              dphase_q, dphase_d;
  logic [AHB_AW-1:0] addr_q;
  logic [2:0]        size_q;
  logic              write_q;

  logic              ready;
  logic              hresp_c;
  logic              sel_ok;
  logic              accept;
  logic              base_err;
  logic              burst_viol;
  logic              xfer_err;

  logic [AHB_DW-1:0] mem [MEM_DEPTH];
  logic [IdxW-1:0]   idx;
  logic [31:0]       off_b;
  logic [NumBytes-1:0] byte_en;
  logic              mem_we;
  logic              rd_active;

  assign sel_ok = bus.hsel && bus.hreadyin && ready;
  assign accept = sel_ok && bus.htrans[1];

  // Out of range, misaligned to hsize, or wider than the data bus.
  assign base_err = ((bus.haddr >> OffW) >= AHB_AW'(MEM_DEPTH))
                 || (|(bus.haddr & ((AHB_AW'(1) << bus.hsize) - AHB_AW'(1))))
                 || (32'(bus.hsize) > OffW);
  assign xfer_err = base_err || burst_viol;

`ifdef AHB_SLV_BURST_CHECK_EN
  logic [2:0]        burst_q;
  logic              bvalid_q, bvalid_d;
  logic [4:0]        beat_q, beat_d;
  logic [4:0]        beats;
  logic [AHB_AW-1:0] inc, bnd_mask, nxt;
  logic              berr_q;
  logic              is_seq;

  assign is_seq = (bus.htrans == 2'b11);

  // The registered addr/size/write/burst of the last accepted transfer are the previous beat.
  always_comb begin
    case (burst_q)
      3'b000:         beats = 5'd1;
      3'b001:         beats = 5'd0;  // INCR: unbounded
      3'b010, 3'b011: beats = 5'd4;
      3'b100, 3'b101: beats = 5'd8;
      default:        beats = 5'd16;
    endcase
    inc      = AHB_AW'(1) << size_q;
    bnd_mask = (AHB_AW'(beats) << size_q) - AHB_AW'(1);
    if (!burst_q[0] && (burst_q != 3'b000)) begin
      nxt = (addr_q & ~bnd_mask) | ((addr_q + inc) & bnd_mask);
    end else begin
      nxt = addr_q + inc;
    end
    burst_viol = accept && is_seq &&
                 (!bvalid_q || (bus.hsize != size_q) || (bus.hwrite != write_q) ||
                  (bus.hburst != burst_q) || (bus.haddr != nxt) ||
                  ((beats != 5'd0) && (beat_q >= beats)));
    bvalid_d = bvalid_q;
    beat_d   = beat_q;
    if (accept) begin
      if (base_err || burst_viol) begin
        bvalid_d = 1'b0;
      end else if (is_seq) begin
        if (beat_q != 5'h1f) beat_d = beat_q + 5'd1;
      end else begin
        bvalid_d = 1'b1;
        beat_d   = 5'd1;
      end
    end else if (sel_ok && (bus.htrans == 2'b00)) begin
      bvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_q  <= 3'b000;
      bvalid_q <= 1'b0;
      beat_q   <= 5'd0;
      berr_q   <= 1'b0;
    end else begin
      bvalid_q <= bvalid_d;
      beat_q   <= beat_d;
      if (accept) burst_q <= bus.hburst;
      if (burst_viol) berr_q <= 1'b1;
    end
  end

  assign burst_err = berr_q;
`else
  assign burst_viol = 1'b0;
  assign burst_err  = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dphase_d = dphase_q;
    ready    = 1'b1;
    hresp_c  = 1'b0;
    unique case (state_q)
      StIdle, StErr2: begin
        hresp_c  = (state_q == StErr2);
        dphase_d = accept && !xfer_err;
        if (accept && xfer_err) begin
          state_d = StErr1;
        end else if (accept && (wait_cfg != 4'd0)) begin
          state_d = StWait;
          cnt_d   = wait_cfg;
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        ready = 1'b0;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StIdle;
      end
      StErr1: begin
        ready   = 1'b0;
        hresp_c = 1'b1;
        state_d = StErr2;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      dphase_q <= 1'b0;
      addr_q   <= '0;
      size_q   <= 3'd0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dphase_q <= dphase_d;
      if (accept) begin
        addr_q  <= bus.haddr;
        size_q  <= bus.hsize;
        write_q <= bus.hwrite;
      end
    end
  end

  // A good data phase always completes in StIdle, so that is where read/write take effect.
  assign idx       = addr_q[OffW +: IdxW];
  assign off_b     = 32'(addr_q[OffW-1:0]);
  assign mem_we    = !reset && dphase_q && write_q && (state_q == StIdle);
  assign rd_active = dphase_q && !write_q && (state_q == StIdle);

  always_comb begin
    byte_en = '0;
    for (int unsigned i = 0; i < NumBytes; i++) begin
      byte_en[i] = (i >= off_b) && (i < off_b + (32'd1 << size_q));
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < NumBytes; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= bus.hwdata[8*i +: 8];
      end
    end
  end

  assign bus.hreadyout = ready;
  assign bus.hresp     = hresp_c;
  assign bus.hrdata    = rd_active ? mem[idx] : '0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed self-checking bench for ahb_slave_mem; expectations follow AHB_SLV_BURST_CHECK_EN.
module tb_ahb_slave_mem;

  localparam logic [1:0] TrIdle = 2'b00;
  localparam logic [1:0] TrNs   = 2'b10;
  localparam logic [1:0] TrSeq  = 2'b11;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] wait_cfg;
  logic       burst_err;
  logic       stall;
  int         n_checks = 0;
  int         n_pass   = 0;
  int         lows;
  logic       done;

  ahb_slave_mem_if #(.AHB_DW(32), .AHB_AW(32)) bif ();

  ahb_slave_mem #(.AHB_DW(32), .AHB_AW(32), .MEM_DEPTH(1024)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bif.slave),
    .wait_cfg  (wait_cfg),
    .burst_err (burst_err)
  );

  always #5 clk = ~clk;

  // Bus HREADY follows this slave unless another slave is stalling.
  assign bif.hreadyin = stall ? 1'b0 : bif.hreadyout;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input logic [1:0] tr, input logic [31:0] a, input logic w,
                       input logic [2:0] sz, input logic [2:0] bu, input logic [31:0] wd);
    bif.hsel   = 1'b1;
    bif.htrans = tr;
    bif.haddr  = a;
    bif.hwrite = w;
    bif.hsize  = sz;
    bif.hburst = bu;
    bif.hwdata = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    reset    = 1'b1;
    stall    = 1'b0;
    wait_cfg = 4'd0;
    drive(TrIdle, 32'h0, 1'b0, 3'd2, 3'd0, 32'h0);
    bif.hsel = 1'b0;
    tick();
    tick();
    settle();
    check_val("rst hreadyout", bif.hreadyout, 1);
    check_val("rst hresp", bif.hresp, 0);
    check_val("rst hrdata", bif.hrdata, 0);
    check_val("rst burst_err", burst_err, 0);
    reset = 1'b0;
    tick();

    // Write then pipelined read, zero wait states.
    drive(TrNs, 32'h10, 1'b1, 3'd2, 3'd0, 32'h0);
    settle();
    check_val("t1 ready addr", bif.hreadyout, 1);
    tick();
    drive(TrNs, 32'h10, 1'b0, 3'd2, 3'd0, 32'hDEADBEEF);
    settle();
    check_val("t1 ready wr", bif.hreadyout, 1);
    check_val("t1 resp wr", bif.hresp, 0);
    check_val("t1 rdata during wr", bif.hrdata, 0);
    tick();
    drive(TrIdle, 32'h0, 1'b0, 3'd2, 3'd0, 32'h0);
    settle();
    check_val("t1 ready rd", bif.hreadyout, 1);
    check_val("t1 rdata", bif.hrdata, 32'hDEADBEEF);
    tick();

    // Three wait states on a read; wait_cfg changed mid-phase must not matter.
    drive(TrNs, 32'h20, 1'b1, 3'd2, 3'd0, 32'h0);
    tick();
    drive(TrIdle, 32'h0, 1'b0, 3'd2, 3'd0, 32'hCAFEF00D);
    tick();
    wait_cfg = 4'd3;
    drive(TrNs, 32'h20, 1'b0, 3'd2, 3'd0, 32'h0);
    tick();
    drive(TrIdle, 32'h0, 1'b0, 3'd2, 3'd0, 32'h0);
    wait_cfg = 4'd7;
    lows = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      settle();
      check_val("t2 hresp", bif.hresp, 0);
      if (bif.hreadyout) begin
        done = 1'b1;
        check_val("t2 rdata", bif.hrdata, 32'hCAFEF00D);
      end else begin
        lows++;
        tick();
      end
    end
    check_val("t2 completed", done, 1);
    check_val("t2 low cycles", lows, 3);
    tick();
    wait_cfg = 4'd0;

    // Byte then halfword write over a full word.
    drive(TrNs, 32'h40, 1'b1, 3'd2, 3'd0, 32'h0);
    tick();
    drive(TrNs, 32'h41, 1'b1, 3'd0, 3'd0, 32'h11223344);
    tick();
    drive(TrNs, 32'h40, 1'b0, 3'd2, 3'd0, 32'h0000AB00);
    tick();
    drive(TrNs, 32'h42, 1'b1, 3'd1, 3'd0, 32'h0);
    settle();
    check_val("t3 byte write", bif.hrdata, 32'h1122AB44);
    tick();
    drive(TrNs, 32'h40, 1'b0, 3'd2, 3'd0, 32'h55660000);
    tick();
    drive(TrIdle, 32'h0, 1'b0, 3'd2, 3'd0, 32'h0);
    settle();
    check_val("t3 half write", bif.hrdata, 32'h5566AB44);
    tick();

    // Error responses: out of range, misaligned, oversize.
    drive(TrNs, 32'h0, 1'b1, 3'd2, 3'd0, 32'h0);
    tick();
    drive(TrNs, 32'd4096, 1'b1, 3'd2, 3'd0, 32'h12345678);
    settle();
    check_val("t4 resp before err", bif.hresp, 0);
    tick();
    drive(TrIdle, 32'h0, 1'b0, 3'd2, 3'd0, 32'hFFFFFFFF);
    settle();
    check_val("t4 err1 ready", bif.hreadyout, 0);
    check_val("t4 err1 resp", bif.hresp, 1);
    tick();
    drive(TrNs, 32'h0, 1'b0, 3'd2, 3'd0, 32'hFFFFFFFF);
    settle();
    check_val("t4 err2 ready", bif.hreadyout, 1);
    check_val("t4 err2 resp", bif.hresp, 1);
    tick();
    drive(TrNs, 32'h6, 1'b1, 3'd2, 3'd0, 32'h0);
    settle();
    check_val("t4 word0 intact", bif.hrdata, 32'h12345678);
    check_val("t4 resp after err", bif.hresp, 0);
    tick();
    drive(TrIdle, 32'h0, 1'b0, 3'd2, 3'd0, 32'hFFFFFFFF);
    settle();
    check_val("t4 misalign resp", bif.hresp, 1);
    check_val("t4 misalign ready", bif.hreadyout, 0);
    tick();
    drive(TrNs, 32'h0, 1'b1, 3'd3, 3'd0, 32'hFFFFFFFF);
    tick();
    drive(TrIdle, 32'h0, 1'b0, 3'd2, 3'd0, 32'hFFFFFFFF);
    settle();
    check_val("t4 oversize resp", bif.hresp, 1);
    check_val("t4 oversize ready", bif.hreadyout, 0);
    tick();
    drive(TrNs, 32'h0, 1'b0, 3'd2, 3'd0, 32'h0);
    tick();
    drive(TrIdle, 32'h0, 1'b0, 3'd2, 3'd0, 32'h0);
    settle();
    check_val("t4 word0 final", bif.hrdata, 32'h12345678);
    tick();

    // WRAP4 word burst from 0x38, then a bad second beat.
    drive(TrNs, 32'h38, 1'b0, 3'd2, 3'b010, 32'h0);
    tick();
    drive(TrSeq, 32'h3C, 1'b0, 3'd2, 3'b010, 32'h0);
    settle();
    check_val("t5 wrap beat0", bif.hresp, 0);
    tick();
    drive(TrSeq, 32'h30, 1'b0, 3'd2, 3'b010, 32'h0);
    settle();
    check_val("t5 wrap beat1", bif.hresp, 0);
    tick();
    drive(TrSeq, 32'h34, 1'b0, 3'd2, 3'b010, 32'h0);
    settle();
    check_val("t5 wrap beat2", bif.hresp, 0);
    tick();
    drive(TrIdle, 32'h0, 1'b0, 3'd2, 3'd0, 32'h0);
    settle();
    check_val("t5 wrap beat3", bif.hresp, 0);
    check_val("t5 wrap ready", bif.hreadyout, 1);
    check_val("t5 no burst_err", burst_err, 0);
    tick();
    drive(TrNs, 32'h38, 1'b0, 3'd2, 3'b010, 32'h0);
    tick();
    drive(TrSeq, 32'h40, 1'b0, 3'd2, 3'b010, 32'h0);
    settle();
    check_val("t5 bad beat0", bif.hresp, 0);
    tick();
    drive(TrIdle, 32'h0, 1'b0, 3'd2, 3'd0, 32'h0);
    settle();
`ifdef AHB_SLV_BURST_CHECK_EN
    check_val("t5 bad resp", bif.hresp, 1);
    check_val("t5 bad ready", bif.hreadyout, 0);
    check_val("t5 burst_err", burst_err, 1);
`else
    check_val("t5 bad resp", bif.hresp, 0);
    check_val("t5 bad ready", bif.hreadyout, 1);
    check_val("t5 burst_err", burst_err, 0);
`endif
    tick();
    tick();

    // Stalled address phase (hreadyin low) must not be accepted.
    wait_cfg = 4'd3;
    stall = 1'b1;
    drive(TrNs, 32'h40, 1'b0, 3'd2, 3'd0, 32'h0);
    tick();
    stall = 1'b0;
    drive(TrIdle, 32'h0, 1'b0, 3'd2, 3'd0, 32'h0);
    settle();
    check_val("t6 stall ready", bif.hreadyout, 1);
    check_val("t6 stall rdata", bif.hrdata, 0);
    tick();

    // Reset during the second wait cycle of a write drops the write.
    wait_cfg = 4'd0;
    drive(TrNs, 32'h80, 1'b1, 3'd2, 3'd0, 32'h0);
    tick();
    drive(TrIdle, 32'h0, 1'b0, 3'd2, 3'd0, 32'hA5A5A5A5);
    tick();
    wait_cfg = 4'd4;
    drive(TrNs, 32'h80, 1'b1, 3'd2, 3'd0, 32'h0);
    tick();
    drive(TrIdle, 32'h0, 1'b0, 3'd2, 3'd0, 32'hFFFFFFFF);
    settle();
    check_val("t7 wait1 ready", bif.hreadyout, 0);
    tick();
    reset = 1'b1;
    settle();
    check_val("t7 wait2 ready", bif.hreadyout, 0);
    tick();
    reset = 1'b0;
    settle();
    check_val("t7 rst ready", bif.hreadyout, 1);
    check_val("t7 rst resp", bif.hresp, 0);
    check_val("t7 rst rdata", bif.hrdata, 0);
    check_val("t7 rst burst_err", burst_err, 0);
    tick();
    wait_cfg = 4'd0;
    drive(TrNs, 32'h80, 1'b0, 3'd2, 3'd0, 32'h0);
    tick();
    drive(TrIdle, 32'h0, 1'b0, 3'd2, 3'd0, 32'h0);
    settle();
    check_val("t7 word intact", bif.hrdata, 32'hA5A5A5A5);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
